// File: rtl/intm_rs_pkg.sv
// Shared types and default sizes for the integer multiply reservation station.
// Optional build macro: INTM_RS_AGE_ORDER_EN (oldest-first select instead of lowest-index).
package intm_rs_pkg;

    localparam int INTM_RS_DEPTH_DEF = 4;
    localparam int CDB_WIDTH_DEF     = 3;
    localparam int PRF_IDX_W_DEF     = 6;
    localparam int ROB_IDX_W_DEF     = 5;

    typedef enum logic [1:0] {
        MD_MUL    = 2'd0,
        MD_MULH   = 2'd1,
        MD_MULHSU = 2'd2,
        MD_MULHU  = 2'd3
    } md_op_e;

    typedef struct packed {
        logic [ROB_IDX_W_DEF-1:0] rob_id;
        logic [4:0]               rd_arch;
        logic [PRF_IDX_W_DEF-1:0] rd_phy;
        md_op_e                   fu_opcode;
        logic [31:0]              rs1_value;
        logic [31:0]              rs2_value;
    } intm_rs_reg_t;

    typedef struct packed {
        logic                     valid;
        logic                     rs1_rdy;
        logic                     rs2_rdy;
        logic [PRF_IDX_W_DEF-1:0] rs1_phy;
        logic [PRF_IDX_W_DEF-1:0] rs2_phy;
        logic [31:0]              rs1_value;
        logic [31:0]              rs2_value;
        logic [ROB_IDX_W_DEF-1:0] rob_id;
        logic [4:0]               rd_arch;
        logic [PRF_IDX_W_DEF-1:0] rd_phy;
        md_op_e                   fu_opcode;
    } intm_rs_entry_t;

    function automatic intm_rs_reg_t entry_to_pkt(input intm_rs_entry_t e);
        intm_rs_reg_t p;
        p.rob_id    = e.rob_id;
        p.rd_arch   = e.rd_arch;
        p.rd_phy    = e.rd_phy;
        p.fu_opcode = e.fu_opcode;
        p.rs1_value = e.rs1_value;
        p.rs2_value = e.rs2_value;
        return p;
    endfunction

endpackage

// File: rtl/intm_rs_select.sv
// Combinational issue picker: issuable vector in, one-hot grant out.
// With INTM_RS_AGE_ORDER_EN the oldest issuable entry wins, otherwise the lowest index.
module intm_rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            issuable,
`ifdef INTM_RS_AGE_ORDER_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
`endif
    output logic [DEPTH-1:0]            grant
);

    logic [DEPTH-1:0] cand;

`ifdef INTM_RS_AGE_ORDER_EN
    // older[j][i] set means entry j was dispatched before entry i.
    always_comb begin
        cand = issuable;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (issuable[j] && older[j][i]) begin
                    cand[i] = 1'b0;
                end
            end
        end
    end
`else
    assign cand = issuable;
`endif

    always_comb begin
        grant = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intm_rs.sv
// Integer multiply reservation station: buffers MUL-family uops, snoops the CDB, issues one ready op per cycle.
// Optional build macro: INTM_RS_AGE_ORDER_EN (age-matrix oldest-first select).
module intm_rs
    import intm_rs_pkg::*;
#(
    parameter int INTM_RS_DEPTH = INTM_RS_DEPTH_DEF,
    parameter int CDB_WIDTH     = CDB_WIDTH_DEF,
    parameter int PRF_IDX_W     = PRF_IDX_W_DEF,
    parameter int ROB_IDX_W     = ROB_IDX_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                dis_valid,
    output logic                                dis_ready,
    input  logic [ROB_IDX_W-1:0]                dis_rob_id,
    input  logic [4:0]                          dis_rd_arch,
    input  logic [PRF_IDX_W-1:0]                dis_rd_phy,
    input  logic [1:0]                          dis_fu_opcode,
    input  logic [PRF_IDX_W-1:0]                dis_rs1_phy,
    input  logic [PRF_IDX_W-1:0]                dis_rs2_phy,
    input  logic                                dis_rs1_rdy,
    input  logic                                dis_rs2_rdy,
    input  logic [31:0]                         dis_rs1_value,
    input  logic [31:0]                         dis_rs2_value,
    input  logic [CDB_WIDTH-1:0]                cdb_valid,
    input  logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] cdb_rd_phy,
    input  logic [CDB_WIDTH-1:0][31:0]          cdb_rd_value,
    output logic                                fu_valid,
    input  logic                                fu_ready,
    output intm_rs_reg_t                        fu_pkt
);

    localparam int IDX_W = $clog2(INTM_RS_DEPTH);

    intm_rs_entry_t           ent_q   [INTM_RS_DEPTH];
    intm_rs_entry_t           ent_nxt [INTM_RS_DEPTH];
    intm_rs_entry_t           dis_ent;
    logic [INTM_RS_DEPTH-1:0] issuable;
    logic [INTM_RS_DEPTH-1:0] free_vec;
    logic [INTM_RS_DEPTH-1:0] grant;
    logic [IDX_W-1:0]         free_idx;
    logic [IDX_W-1:0]         sel_idx;
    logic                     sel_any;
    logic                     dis_fire;
    logic                     iss_fire;

    // Lowest CDB port wins: scan high to low so the last hit is the lowest index.
    function automatic intm_rs_entry_t wake(input intm_rs_entry_t e);
        intm_rs_entry_t w;
        w = e;
        for (int p = CDB_WIDTH - 1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_rd_phy[p] != '0) begin
                if (!e.rs1_rdy && cdb_rd_phy[p] == e.rs1_phy) begin
                    w.rs1_rdy   = 1'b1;
                    w.rs1_value = cdb_rd_value[p];
                end
                if (!e.rs2_rdy && cdb_rd_phy[p] == e.rs2_phy) begin
                    w.rs2_rdy   = 1'b1;
                    w.rs2_value = cdb_rd_value[p];
                end
            end
        end
        return w;
    endfunction

    always_comb begin
        issuable = '0;
        free_vec = '0;
        for (int i = 0; i < INTM_RS_DEPTH; i++) begin
            issuable[i] = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
            free_vec[i] = !ent_q[i].valid;
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = INTM_RS_DEPTH - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < INTM_RS_DEPTH; i++) begin
            if (grant[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel_any   = |grant;
    assign dis_ready = (|free_vec) && !rst && !flush;
    assign fu_valid  = sel_any && !rst && !flush;
    assign dis_fire  = dis_valid && dis_ready;
    assign iss_fire  = fu_valid && fu_ready;
    assign fu_pkt    = entry_to_pkt(ent_q[sel_idx]);

    // The incoming op snoops the same broadcasts so a same-cycle wakeup is not lost.
    always_comb begin
        dis_ent           = '0;
        dis_ent.valid     = 1'b1;
        dis_ent.rs1_rdy   = dis_rs1_rdy;
        dis_ent.rs2_rdy   = dis_rs2_rdy;
        dis_ent.rs1_phy   = dis_rs1_phy;
        dis_ent.rs2_phy   = dis_rs2_phy;
        dis_ent.rs1_value = dis_rs1_value;
        dis_ent.rs2_value = dis_rs2_value;
        dis_ent.rob_id    = dis_rob_id;
        dis_ent.rd_arch   = dis_rd_arch;
        dis_ent.rd_phy    = dis_rd_phy;
        dis_ent.fu_opcode = md_op_e'(dis_fu_opcode);
        dis_ent           = wake(dis_ent);
    end

    always_comb begin
        for (int i = 0; i < INTM_RS_DEPTH; i++) begin
            ent_nxt[i] = ent_q[i].valid ? wake(ent_q[i]) : ent_q[i];
        end
        if (iss_fire) begin
            ent_nxt[sel_idx].valid = 1'b0;
        end
        if (dis_fire) begin
            ent_nxt[free_idx] = dis_ent;
        end
        if (flush) begin
            for (int i = 0; i < INTM_RS_DEPTH; i++) begin
                ent_nxt[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < INTM_RS_DEPTH; i++) begin
            if (rst) begin
                ent_q[i].valid <= 1'b0;
            end else begin
                ent_q[i] <= ent_nxt[i];
            end
        end
    end

`ifdef INTM_RS_AGE_ORDER_EN
    logic [INTM_RS_DEPTH-1:0][INTM_RS_DEPTH-1:0] older_q;
    logic [INTM_RS_DEPTH-1:0][INTM_RS_DEPTH-1:0] older_nxt;

    // A new entry is older than nobody; every surviving entry becomes older than it.
    always_comb begin
        older_nxt = older_q;
        if (iss_fire) begin
            older_nxt[sel_idx] = '0;
        end
        if (dis_fire) begin
            older_nxt[free_idx] = '0;
            for (int j = 0; j < INTM_RS_DEPTH; j++) begin
                older_nxt[j][free_idx] = ent_q[j].valid && !(iss_fire && sel_idx == IDX_W'(j));
            end
        end
        if (flush) begin
            older_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            older_q <= '0;
        end else begin
            older_q <= older_nxt;
        end
    end

    intm_rs_select #(.DEPTH(INTM_RS_DEPTH)) u_select (
        .issuable (issuable),
        .older    (older_q),
        .grant    (grant)
    );
`else
    intm_rs_select #(.DEPTH(INTM_RS_DEPTH)) u_select (
        .issuable (issuable),
        .grant    (grant)
    );
`endif

endmodule

// File: tb/tb_intm_rs.sv
// Bench for intm_rs: directed scenarios plus random traffic against a slot-level reference model.
// Honours INTM_RS_AGE_ORDER_EN in the model (oldest dispatch wins instead of lowest slot).
module tb_intm_rs;
    import intm_rs_pkg::*;

    localparam int DEPTH = 4;
    localparam int CDBW  = 3;
    localparam int PW    = 6;
    localparam int RW    = 5;
    localparam int PKT_W = $bits(intm_rs_reg_t);
    localparam int EW    = PKT_W + 2;

    // clock / reset / DUT signals
    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic                      dis_valid;
    logic                      dis_ready;
    logic [RW-1:0]             dis_rob_id;
    logic [4:0]                dis_rd_arch;
    logic [PW-1:0]             dis_rd_phy;
    logic [1:0]                dis_fu_opcode;
    logic [PW-1:0]             dis_rs1_phy;
    logic [PW-1:0]             dis_rs2_phy;
    logic                      dis_rs1_rdy;
    logic                      dis_rs2_rdy;
    logic [31:0]               dis_rs1_value;
    logic [31:0]               dis_rs2_value;
    logic [CDBW-1:0]           cdb_valid;
    logic [CDBW-1:0][PW-1:0]   cdb_rd_phy;
    logic [CDBW-1:0][31:0]     cdb_rd_value;
    logic                      fu_valid;
    logic                      fu_ready;
    intm_rs_reg_t              fu_pkt;

    always #5 clk = ~clk;

    intm_rs dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .dis_valid     (dis_valid),
        .dis_ready     (dis_ready),
        .dis_rob_id    (dis_rob_id),
        .dis_rd_arch   (dis_rd_arch),
        .dis_rd_phy    (dis_rd_phy),
        .dis_fu_opcode (dis_fu_opcode),
        .dis_rs1_phy   (dis_rs1_phy),
        .dis_rs2_phy   (dis_rs2_phy),
        .dis_rs1_rdy   (dis_rs1_rdy),
        .dis_rs2_rdy   (dis_rs2_rdy),
        .dis_rs1_value (dis_rs1_value),
        .dis_rs2_value (dis_rs2_value),
        .cdb_valid     (cdb_valid),
        .cdb_rd_phy    (cdb_rd_phy),
        .cdb_rd_value  (cdb_rd_value),
        .fu_valid      (fu_valid),
        .fu_ready      (fu_ready),
        .fu_pkt        (fu_pkt)
    );

    // scoreboard state: one expected {fu_valid, dis_ready, pkt} word per cycle
    logic [EW-1:0] exp_q[$];
    int            total = 0;
    int            bad   = 0;
    bit            running = 1'b0;

    // reference model: a set of slots, each holding an op and what is known about its sources
    typedef struct {
        bit           v;
        bit           r1;
        bit           r2;
        logic [PW-1:0] t1;
        logic [PW-1:0] t2;
        logic [31:0]  x1;
        logic [31:0]  x2;
        intm_rs_reg_t meta;
        int unsigned  seq;
    } mslot_t;

    mslot_t      m [DEPTH];
    int unsigned seq_ctr = 0;

    function automatic mslot_t m_wake(input mslot_t s);
        mslot_t o;
        o = s;
        for (int p = 0; p < CDBW; p++) begin
            if (cdb_valid[p] && cdb_rd_phy[p] != 0) begin
                if (!o.r1 && cdb_rd_phy[p] == s.t1) begin
                    o.r1 = 1'b1;
                    o.x1 = cdb_rd_value[p];
                end
                if (!o.r2 && cdb_rd_phy[p] == s.t2) begin
                    o.r2 = 1'b1;
                    o.x2 = cdb_rd_value[p];
                end
            end
        end
        return o;
    endfunction

    task automatic model_cycle();
        int           pick;
        int           fr;
        bit           fv;
        bit           dr;
        intm_rs_reg_t p;
        mslot_t       n;
        pick = -1;
        fr   = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m[i].v && fr < 0) fr = i;
            if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef INTM_RS_AGE_ORDER_EN
                if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        dr = !rst && !flush && (fr >= 0);
        fv = !rst && !flush && (pick >= 0);
        p  = '0;
        if (fv) begin
            p           = m[pick].meta;
            p.rs1_value = m[pick].x1;
            p.rs2_value = m[pick].x2;
        end
        exp_q.push_back({fv, dr, p});
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].v) m[i] = m_wake(m[i]);
            end
            if (fv && fu_ready) m[pick].v = 1'b0;
            if (dis_valid && dr) begin
                n.v              = 1'b1;
                n.r1             = dis_rs1_rdy;
                n.r2             = dis_rs2_rdy;
                n.t1             = dis_rs1_phy;
                n.t2             = dis_rs2_phy;
                n.x1             = dis_rs1_value;
                n.x2             = dis_rs2_value;
                n.meta           = '0;
                n.meta.rob_id    = dis_rob_id;
                n.meta.rd_arch   = dis_rd_arch;
                n.meta.rd_phy    = dis_rd_phy;
                n.meta.fu_opcode = md_op_e'(dis_fu_opcode);
                n.seq            = seq_ctr;
                seq_ctr++;
                m[fr] = m_wake(n);
            end
        end
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic step();
        model_cycle();
        @(negedge clk);
        dis_valid = 1'b0;
        cdb_valid = '0;
        flush     = 1'b0;
    endtask

    task automatic set_dis(input logic [RW-1:0] rob, input md_op_e op,
                           input logic [PW-1:0] t1, input bit r1, input logic [31:0] v1,
                           input logic [PW-1:0] t2, input bit r2, input logic [31:0] v2);
        dis_valid     = 1'b1;
        dis_rob_id    = rob;
        dis_rd_arch   = 5'($urandom_range(0, 31));
        dis_rd_phy    = PW'($urandom_range(1, 63));
        dis_fu_opcode = op;
        dis_rs1_phy   = t1;
        dis_rs1_rdy   = r1;
        dis_rs1_value = v1;
        dis_rs2_phy   = t2;
        dis_rs2_rdy   = r2;
        dis_rs2_value = v2;
    endtask

    task automatic set_cdb(input int port, input logic [PW-1:0] tag, input logic [31:0] val);
        cdb_valid[port]    = 1'b1;
        cdb_rd_phy[port]   = tag;
        cdb_rd_value[port] = val;
    endtask

    // monitor: samples one time unit before each rising edge
    initial begin
        logic [EW-1:0]    got;
        logic [EW-1:0]    exp;
        logic [PKT_W-1:0] pv;
        forever begin
            @(negedge clk);
            #4;
            if (running) begin
                pv = fu_pkt;
                if (!fu_valid) pv = '0;
                got = {fu_valid, dis_ready, pv};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL no_expectation t=%0t got fv=%0b dr=%0b", $time, fu_valid, dis_ready);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL cycle_check t=%0t got fv=%0b dr=%0b pkt=%h exp fv=%0b dr=%0b pkt=%h",
                                 $time, got[EW-1], got[EW-2], got[PKT_W-1:0],
                                 exp[EW-1], exp[EW-2], exp[PKT_W-1:0]);
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        dis_valid     = 1'b0;
        dis_rob_id    = '0;
        dis_rd_arch   = '0;
        dis_rd_phy    = '0;
        dis_fu_opcode = '0;
        dis_rs1_phy   = '0;
        dis_rs2_phy   = '0;
        dis_rs1_rdy   = 1'b0;
        dis_rs2_rdy   = 1'b0;
        dis_rs1_value = '0;
        dis_rs2_value = '0;
        cdb_valid     = '0;
        cdb_rd_phy    = '0;
        cdb_rd_value  = '0;
        fu_ready      = 1'b0;
        @(negedge clk);
        running = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // ready MUL 7 x 6 issues next cycle, slot free after
        fu_ready = 1'b1;
        set_dis(5'd1, MD_MUL, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 32'd6);
        repeat (3) step();

        // MULHU waits on tag 12, woken via CDB port 1
        set_dis(5'd2, MD_MULHU, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd3);
        repeat (3) step();
        set_cdb(1, 6'd12, 32'hFFFF_FFFF);
        repeat (3) step();

        // same-cycle dispatch and broadcast of rs2 tag 9
        set_dis(5'd3, MD_MULH, 6'd0, 1'b1, 32'd11, 6'd9, 1'b0, 32'd0);
        set_cdb(0, 6'd9, 32'd5);
        repeat (3) step();

        // two ports hit the same tag: port 0 value must win
        set_dis(5'd4, MD_MULHSU, 6'd14, 1'b0, 32'd0, 6'd0, 1'b1, 32'd2);
        step();
        set_cdb(2, 6'd14, 32'hBBBB_0002);
        set_cdb(0, 6'd14, 32'hAAAA_0000);
        repeat (3) step();

        // fill with non-ready ops, wake slot 2, refill slot 2
        for (int k = 0; k < 4; k++) begin
            set_dis(RW'(8 + k), MD_MUL, PW'(30 + k), 1'b0, 32'd0, 6'd0, 1'b1, 32'd9);
            step();
        end
        set_dis(5'd20, MD_MUL, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
        step();
        set_cdb(0, 6'd32, 32'h0000_1234);
        step();
        step();
        set_dis(5'd21, MD_MULH, 6'd0, 1'b1, 32'h8000_0000, 6'd0, 1'b1, 32'd3);
        repeat (3) step();

        // a tag-0 broadcast must not wake a source waiting on tag 0
        set_cdb(0, 6'd0, 32'hDEAD_BEEF);
        step();
        flush = 1'b1;
        repeat (2) step();
        set_dis(5'd22, MD_MUL, 6'd0, 1'b0, 32'd0, 6'd0, 1'b1, 32'd4);
        step();
        set_cdb(1, 6'd0, 32'hDEAD_BEEF);
        repeat (3) step();
        flush = 1'b1;
        step();

        // stall two ready ops, then flush with dispatch pending
        fu_ready = 1'b0;
        set_dis(5'd23, MD_MUL, 6'd0, 1'b1, 32'd100, 6'd0, 1'b1, 32'd200);
        step();
        set_dis(5'd24, MD_MULHU, 6'd0, 1'b1, 32'd300, 6'd0, 1'b1, 32'd400);
        step();
        repeat (5) step();
        flush    = 1'b1;
        fu_ready = 1'b1;
        set_dis(5'd25, MD_MUL, 6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd5);
        step();
        repeat (3) step();

        // age scenario: A(slot0, waits), B(slot1, ready), A issues, C reuses slot0
        fu_ready = 1'b0;
        set_dis(5'd26, MD_MUL, 6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1);
        step();
        set_dis(5'd27, MD_MULH, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd2);
        step();
        set_cdb(0, 6'd20, 32'h11);
        step();
        fu_ready = 1'b1;
        step();
        fu_ready = 1'b0;
        set_dis(5'd28, MD_MULHSU, 6'd0, 1'b1, 32'd3, 6'd0, 1'b1, 32'd3);
        step();
        step();
        fu_ready = 1'b1;
        repeat (3) step();

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 60) begin
                set_dis(RW'($urandom_range(0, 31)), md_op_e'($urandom_range(0, 3)),
                        PW'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom(),
                        PW'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom());
            end
            for (int p = 0; p < CDBW; p++) begin
                if ($urandom_range(0, 99) < 40) set_cdb(p, PW'($urandom_range(0, 15)), $urandom());
            end
            fu_ready = ($urandom_range(0, 99) < 70);
            flush    = ($urandom_range(0, 49) == 0);
            step();
        end
        flush = 1'b1;
        repeat (2) step();

        running = 1'b0;
        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intm_rs.md
Name: intm_rs

Overview:
Integer multiply reservation station. It buffers dispatched MUL/MULH/MULHSU/MULHU micro-ops and snoops all CDB broadcasts to wake pending source operands. It issues one fully-ready op per cycle into the multiply functional unit through a valid/ready handshake. It sits between rename/dispatch and the multiply FU, and acts as the initiator side of that FU's prv_valid/prv_ready and intm_rs_reg_t input.

Parameters:
INTM_RS_DEPTH, 4, number of entries (power of two, ≥2)
CDB_WIDTH, 3, number of CDB broadcast ports snooped
PRF_IDX_W, 6, physical register index width
ROB_IDX_W, 5, ROB index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush (mispredict/exception); drops all entries
dis_valid  in  1  dispatch request
dis_ready  out  1  at least one free entry and not rst/flush
dis_rob_id  in  ROB_IDX_W  ROB index
dis_rd_arch  in  5  architectural destination
dis_rd_phy  in  PRF_IDX_W  physical destination
dis_fu_opcode  in  2  MD_MUL/MD_MULH/MD_MULHSU/MD_MULHU
dis_rs1_phy, dis_rs2_phy  in  PRF_IDX_W each  source physical tags
dis_rs1_rdy, dis_rs2_rdy  in  1 each  source value already valid
dis_rs1_value, dis_rs2_value  in  32 each  source value (meaningful only when rdy)
cdb_valid  in  CDB_WIDTH  broadcast valid per port
cdb_rd_phy  in  CDB_WIDTH x PRF_IDX_W  broadcast tag
cdb_rd_value  in  CDB_WIDTH x 32  broadcast value
fu_valid  out  1  issue request to the multiply FU
fu_ready  in  1  multiply FU accepts
fu_pkt  out  intm_rs_reg_t  rob_id, rd_arch, rd_phy, fu_opcode, rs1_value, rs2_value

Behaviour:
- Entry state: valid bit, rs1/rs2 rdy bits, tags, values, uop metadata. Reset: all valid=0. Outputs during and after reset: fu_valid=0, fu_pkt='0 contents irrelevant. dis_ready is 0 while rst=1 and 1 in the first cycle after reset.
- Dispatch: an op is accepted when dis_valid && dis_ready. It is written into the lowest-index free entry, based on registered valid bits. An entry freed by issue in cycle N becomes allocatable in cycle N+1. When full, dis_ready=0.
- Wakeup: for each valid entry and each not-rdy source, a match on cdb_valid[i] && cdb_rd_phy[i]==tag sets rdy and captures the value at the clock edge. The match is also applied to the operand being dispatched in the same cycle, so that an op dispatched with a not-rdy source being broadcast that cycle lands rdy. Broadcasts with rd_phy==0 are ignored. If several ports match, the lowest port index wins.
- Select: an entry is issuable when valid, rs1 rdy, and rs2 rdy, using registered state only, so wakeup-to-issue latency is 1 cycle. By default the lowest index is picked. fu_valid = any issuable && !flush. fu_pkt is driven combinationally from the selected entry.
- Issue: fu_valid && fu_ready clears the selected entry's valid bit at the edge. fu_pkt must stay stable while fu_valid && !fu_ready, with no reselection to a different entry unless a lower-index entry becomes issuable. A selected-but-stalled entry still snoops harmlessly; its sources are already rdy.
- Flush: at the edge where flush=1, all valid bits clear. Dispatch and issue in that cycle are discarded. fu_valid=0 and dis_ready=0 during flush. Flush and rst together behave as rst.
- Dispatch, issue, and wakeup in the same cycle on different entries are all honoured.

Optional Feature:
INTM_RS_AGE_ORDER_EN: when defined, an INTM_RS_DEPTH² age matrix is maintained. The row for a new entry is set older-than-none at dispatch and cleared on issue or flush. Select picks the oldest issuable entry. Without the macro, select picks the lowest-index issuable entry and no age state exists.

Decomposition:
- Package int_rs_types holds intm_rs_entry_t (valid, rdy bits, tags, values, metadata) and the existing intm_rs_reg_t and MD_* opcodes.
- INTM_RS_DEPTH and CDB_WIDTH are defaults in cpu_params.
- One sub-module, intm_rs_select: a combinational issuable-vector-to-one-hot picker, with age-matrix mode under the macro.

Test Plan:
- Reset, then dispatch MUL with rs1=7, rs2=6 both rdy, fu_ready=1 → fu_valid the next cycle with fu_pkt.rs1_value=7, rs2_value=6, opcode MD_MUL; the entry is freed the following cycle.
- Dispatch MULHU with rs1 tag 12 not rdy; 3 cycles later cdb_valid[1]=1, rd_phy=12, value 0xFFFFFFFF → fu_valid is asserted exactly 1 cycle after the broadcast with rs1_value=0xFFFFFFFF.
- Dispatch with rs2 tag 9 not rdy while cdb port 0 broadcasts tag 9, value 5 in the same cycle → the entry is rdy and issues next cycle with rs2_value=5.
- Fill all 4 entries with non-rdy ops → dis_ready=0. Broadcast wakes entry 2, fu_ready=1 → entry 2 issues; dis_ready=1 the following cycle and the new op lands in slot 2.
- Hold fu_ready=0 for 5 cycles with 2 ready entries → fu_pkt stable on entry 0. Then assert flush → fu_valid=0 next cycle, all entries empty, and no stale issue after flush drops.
- With INTM_RS_AGE_ORDER_EN: dispatch A to slot 0 non-rdy, B to slot 1 rdy, free slot 0, dispatch C to slot 0 rdy → B issues before C.
